// File: rtl/uart_alu_parser.sv
// uart_alu_parser
//   Assembles ALU requests from a byte stream (UART RX side). A packet is an
//   opcode byte, operand A (4 bytes, little-endian), operand B (4 bytes,
//   little-endian) and, when PARSER_CHECKSUM_EN is defined, a check byte
//   equal to the XOR of the nine preceding bytes. A stalled packet is dropped
//   after TimeoutCycles idle cycles with a one-cycle err_o pulse.
//
//   Optional feature macro: PARSER_CHECKSUM_EN (adds the Check state and the
//   XOR accumulator; without it packets are 9 bytes long).
//
// Ports
//   clk_i        : clock, all logic on the rising edge
//   reset_i      : synchronous active-high reset
//   valid_i      : upstream byte valid
//   data_i[7:0]  : upstream byte
//   ready_o      : parser accepts a byte (low only while a request is pending)
//   valid_o      : ALU request valid
//   opcode_o[1:0]: 0 Nop, 1 Add, 2 Mul, 3 Div
//   operand_a_o  : operand A
//   operand_b_o  : operand B
//   ready_i      : ALU accepts the request
//   err_o        : one-cycle pulse when a packet is dropped
module uart_alu_parser #(
  parameter int TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [1:0]  opcode_o,
  output logic [31:0] operand_a_o,
  output logic [31:0] operand_b_o,
  input  logic        ready_i,
  output logic        err_o
);

  localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);

`ifdef PARSER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_OPA, S_OPB, S_CHECK, S_ISSUE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_OPA, S_OPB, S_ISSUE} state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [1:0]  opcode_q, opcode_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        err_q, err_d;
  logic        xfer;
  logic        waiting;
`ifdef PARSER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  function automatic logic [1:0] decode_op(input logic [7:0] b);
    case (b)
      8'h01:   return 2'd1;
      8'h02:   return 2'd2;
      8'h03:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign ready_o     = (state_q != S_ISSUE);
  assign valid_o     = (state_q == S_ISSUE);
  assign opcode_o    = opcode_q;
  assign operand_a_o = opa_q;
  assign operand_b_o = opb_q;
  assign err_o       = err_q;
  assign xfer        = valid_i & ready_o;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    idle_cnt_d = idle_cnt_q;
    opcode_d   = opcode_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    err_d      = 1'b0;
    waiting    = 1'b0;
`ifdef PARSER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          opcode_d = decode_op(data_i);
`ifdef PARSER_CHECKSUM_EN
          csum_d   = data_i;
`endif
          state_d  = S_OPA;
        end
      end
      S_OPA: begin
        waiting = 1'b1;
        if (xfer) begin
          opa_d[{idx_q, 3'b000} +: 8] = data_i;
`ifdef PARSER_CHECKSUM_EN
          csum_d = csum_q ^ data_i;
`endif
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_OPB;
        end
      end
      S_OPB: begin
        waiting = 1'b1;
        if (xfer) begin
          opb_d[{idx_q, 3'b000} +: 8] = data_i;
`ifdef PARSER_CHECKSUM_EN
          csum_d = csum_q ^ data_i;
          if (idx_q == 2'd3) state_d = S_CHECK;
`else
          if (idx_q == 2'd3) state_d = S_ISSUE;
`endif
          idx_d = idx_q + 2'd1;
        end
      end
`ifdef PARSER_CHECKSUM_EN
      S_CHECK: begin
        waiting = 1'b1;
        if (xfer) begin
          if (data_i == csum_q) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      S_ISSUE: begin
        if (ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A byte in the timeout cycle wins: the counter only fires when idle.
    if (waiting && !xfer) begin
      if (idle_cnt_q == TimeoutLast) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 16'd1;
      end
    end else begin
      idle_cnt_d = 16'd0;
    end

    // Every state entry starts with a fresh byte index and idle count.
    if (state_d != state_q) begin
      idx_d      = 2'd0;
      idle_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      idle_cnt_q <= 16'd0;
      opcode_q   <= 2'd0;
      opa_q      <= 32'd0;
      opb_q      <= 32'd0;
      err_q      <= 1'b0;
`ifdef PARSER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      idle_cnt_q <= idle_cnt_d;
      opcode_q   <= opcode_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      err_q      <= err_d;
`ifdef PARSER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_alu_parser.sv
// Self-checking bench for uart_alu_parser: directed vector table, hand-written
// multi-cycle sequences (stall, timeout, byte-wins-timeout, reset mid-packet,
// checksum) and randomized packets checked against a simple packet model.
module tb_uart_alu_parser;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic [7:0]  data_i;
  logic        ready_o;
  logic        valid_o;
  logic [1:0]  opcode_o;
  logic [31:0] operand_a_o;
  logic [31:0] operand_b_o;
  logic        ready_i;
  logic        err_o;

  uart_alu_parser #(.TimeoutCycles(TO)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .opcode_o    (opcode_o),
    .operand_a_o (operand_a_o),
    .operand_b_o (operand_b_o),
    .ready_i     (ready_i),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;
  int err_cnt = 0;
  int valid_cnt = 0;

  // Cycle counters of err_o / valid_o, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (err_o === 1'b1) err_cnt++;
    if (valid_o === 1'b1) valid_cnt++;
  end

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  exp_op;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  task automatic check(input string tag, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", tag, field, act, exp);
    end
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    valid_i = 1'b1;
    data_i  = b;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    data_i  = 8'($urandom);
  endtask

  // Packet model: opcode, A low byte first, B low byte first, optional XOR.
  task automatic build_pkt(input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, output bq_t q);
    q = {};
    q.push_back(op);
    for (int i = 0; i < 4; i++) q.push_back(8'((a >> (8 * i)) & 32'hFF));
    for (int i = 0; i < 4; i++) q.push_back(8'((b >> (8 * i)) & 32'hFF));
`ifdef PARSER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      foreach (q[i]) x = x ^ q[i];
      q.push_back(x);
    end
`endif
  endtask

  task automatic send_q(input bq_t q, input int max_gap,
                        input int hold_idx, input int hold_len);
    foreach (q[i]) begin
      if (i == hold_idx) tick(hold_len);
      else if (i > 0 && max_gap > 0) tick(int'($urandom_range(max_gap, 0)));
      send_byte(q[i]);
    end
  endtask

  function automatic logic [1:0] ref_op(input logic [7:0] op);
    if (op == 8'd1) return 2'd1;
    if (op == 8'd2) return 2'd2;
    if (op == 8'd3) return 2'd3;
    return 2'd0;
  endfunction

  // Called in the first cycle after the last byte; holds ready_i low for
  // `stall` cycles, then accepts.
  task automatic expect_issue(input string tag, input logic [1:0] eop,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input int stall);
    int v0;
    v0 = valid_cnt;
    for (int s = 0; s <= stall; s++) begin
      ready_i = (s == stall);
      check(tag, "valid_o", valid_o, 1);
      check(tag, "ready_o", ready_o, 0);
      check(tag, "opcode_o", opcode_o, eop);
      check(tag, "operand_a_o", operand_a_o, ea);
      check(tag, "operand_b_o", operand_b_o, eb);
      tick(1);
    end
    ready_i = 1'b0;
    check(tag, "valid_after", valid_o, 0);
    check(tag, "ready_after", ready_o, 1);
    check(tag, "valid_cycles", valid_cnt - v0, stall + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    bq_t  q;
    int   e0;
    int   v0;

    vecs[0] = '{8'h01, 32'h01020304, 32'h05060708, 2'd1, 32'h01020304, 32'h05060708};
    vecs[1] = '{8'h7F, 32'h00000000, 32'h00000000, 2'd0, 32'h00000000, 32'h00000000};
    vecs[2] = '{8'h02, 32'hFFFFFFFF, 32'h80000001, 2'd2, 32'hFFFFFFFF, 32'h80000001};
    vecs[3] = '{8'h03, 32'hDEADBEEF, 32'h00000007, 2'd3, 32'hDEADBEEF, 32'h00000007};
    vecs[4] = '{8'h00, 32'h12345678, 32'h9ABCDEF0, 2'd0, 32'h12345678, 32'h9ABCDEF0};
    vecs[5] = '{8'h04, 32'hA5A5A5A5, 32'h5A5A5A5A, 2'd0, 32'hA5A5A5A5, 32'h5A5A5A5A};
    vecs[6] = '{8'hFF, 32'h00000001, 32'hFFFFFFFE, 2'd0, 32'h00000001, 32'hFFFFFFFE};

    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = 8'h00;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    check("reset", "ready_o", ready_o, 1);
    check("reset", "valid_o", valid_o, 0);
    check("reset", "err_o", err_o, 0);
    check("reset", "opcode_o", opcode_o, 0);
    check("reset", "operand_a_o", operand_a_o, 0);
    check("reset", "operand_b_o", operand_b_o, 0);

    // Directed vectors, back to back with no gaps.
    e0 = err_cnt;
    for (int i = 0; i < 7; i++) begin
      build_pkt(vecs[i].op, vecs[i].a, vecs[i].b, q);
      send_q(q, 0, -1, 0);
      expect_issue($sformatf("vec%0d", i), vecs[i].exp_op, vecs[i].exp_a,
                   vecs[i].exp_b, 0);
    end
    check("vectors", "err_count", err_cnt - e0, 0);

    // Downstream stall for 5 cycles, accepted on the 6th.
    build_pkt(8'h02, 32'hCAFEF00D, 32'h0BADBEEF, q);
    send_q(q, 0, -1, 0);
    expect_issue("stall", 2'd2, 32'hCAFEF00D, 32'h0BADBEEF, 5);

    // Timeout: 3 bytes then silence.
    e0 = err_cnt;
    v0 = valid_cnt;
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    tick(TO + 2);
    check("timeout", "err_pulses", err_cnt - e0, 1);
    check("timeout", "valid_cycles", valid_cnt - v0, 0);
    check("timeout", "ready_o", ready_o, 1);
    build_pkt(8'h03, 32'h11223344, 32'h55667788, q);
    send_q(q, 0, -1, 0);
    expect_issue("after_timeout", 2'd3, 32'h11223344, 32'h55667788, 0);

    // A byte arriving in the very cycle the timeout would fire is taken.
    e0 = err_cnt;
    build_pkt(8'h01, 32'h0000FFFF, 32'hFFFF0000, q);
    send_q(q, 0, 1, TO - 1);
    expect_issue("byte_wins", 2'd1, 32'h0000FFFF, 32'hFFFF0000, 0);
    check("byte_wins", "err_pulses", err_cnt - e0, 0);

    // Reset after the 5th byte discards the partial packet silently.
    e0 = err_cnt;
    build_pkt(8'h02, 32'h76543210, 32'hFEDCBA98, q);
    for (int i = 0; i < 5; i++) send_byte(q[i]);
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    check("midreset", "ready_o", ready_o, 1);
    check("midreset", "valid_o", valid_o, 0);
    check("midreset", "opcode_o", opcode_o, 0);
    check("midreset", "operand_a_o", operand_a_o, 0);
    tick(TO + 2);
    check("midreset", "err_pulses", err_cnt - e0, 0);
    send_q(q, 0, -1, 0);
    expect_issue("after_reset", 2'd2, 32'h76543210, 32'hFEDCBA98, 0);
    check("after_reset", "err_pulses", err_cnt - e0, 0);

`ifdef PARSER_CHECKSUM_EN
    // Eight 0x11 bytes cancel out, so the check byte equals the opcode.
    build_pkt(8'h02, 32'h11111111, 32'h11111111, q);
    q[9] = 8'h02;
    send_q(q, 0, -1, 0);
    expect_issue("csum_ok", 2'd2, 32'h11111111, 32'h11111111, 0);
    e0 = err_cnt;
    v0 = valid_cnt;
    q[9] = 8'h00;
    send_q(q, 0, -1, 0);
    check("csum_bad", "valid_o", valid_o, 0);
    tick(2);
    check("csum_bad", "err_pulses", err_cnt - e0, 1);
    check("csum_bad", "valid_cycles", valid_cnt - v0, 0);
`endif

    // Randomized packets with random byte gaps and downstream stalls.
    e0 = err_cnt;
    for (int n = 0; n < 40; n++) begin
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;
      sel = int'($urandom_range(4, 0));
      op  = (sel < 4) ? 8'(sel) : 8'($urandom);
      a   = $urandom;
      b   = $urandom;
      build_pkt(op, a, b, q);
      send_q(q, TO - 3, -1, 0);
      expect_issue($sformatf("rand%0d", n), ref_op(op), a, b,
                   int'($urandom_range(3, 0)));
    end
    check("random", "err_pulses", err_cnt - e0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_alu_parser.md
UART_ALU_PARSER -- requirements
Module: uart_alu_parser

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 1024; idle cycles allowed between bytes of one packet before abort; range 1..65535.
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port valid_i  input  1  upstream (UART RX) byte valid.
REQ-005 SHALL have port data_i  input  8  upstream byte.
REQ-006 SHALL have port ready_o  output  1  parser can accept a byte.
REQ-007 SHALL have port valid_o  output  1  ALU request valid.
REQ-008 SHALL have port opcode_o  output  2  ALU opcode: 0 Nop, 1 Add, 2 Mul, 3 Div.
REQ-009 SHALL have port operand_a_o  output  32  ALU operand A.
REQ-010 SHALL have port operand_b_o  output  32  ALU operand B.
REQ-011 SHALL have port ready_i  input  1  ALU accepts request.
REQ-012 SHALL have port err_o  output  1  one-cycle pulse on a dropped packet.

Function
REQ-013 SHALL transfer a byte only in cycles where valid_i and ready_o are both 1; transfer a request only where valid_o and ready_i are both 1.
REQ-014 SHALL parse packets of: opcode byte, 4 bytes of A (little-endian), 4 bytes of B (little-endian), then the check byte when PARSER_CHECKSUM_EN is defined.
REQ-015 SHALL map the opcode byte 8'h01 to Add, 8'h02 to Mul, 8'h03 to Div, and every other value to Nop; a Nop packet is still fully parsed and issued.
REQ-016 SHALL implement the states Idle, OperandA, OperandB, Check (only with the macro), and Issue.
REQ-017 SHALL make these transitions: Idle to OperandA on the opcode byte; OperandA to OperandB after its 4th byte; OperandB to Check (with the macro) or Issue (without it) after its 4th byte; Check to Issue (match) or Idle (mismatch); Issue to Idle on a request transfer.
REQ-018 SHALL track the byte index within each operand with a 2-bit counter that is cleared on every state entry.
REQ-019 SHALL drive ready_o to 1 in every state except Issue, and to 0 in Issue.
REQ-020 SHALL assert valid_o in the first cycle after the final byte transfers (one-cycle latency), and only in Issue.
REQ-021 SHALL hold opcode_o, operand_a_o and operand_b_o stable while valid_o is 1 and ready_i is 0.
REQ-022 SHALL return to Idle on a request transfer, and SHALL accept the next opcode byte from the following cycle onward.
REQ-023 SHALL keep a 16-bit idle counter that runs only in OperandA, OperandB and Check, and is cleared on each byte transfer and on each state change.
REQ-024 SHALL, when the idle counter reaches TimeoutCycles-1 with no byte transfer, go to Idle, pulse err_o for one cycle, and not assert valid_o.
REQ-025 SHALL let a byte transfer win over a timeout in the same cycle: the byte is accepted and the counter is cleared.
REQ-026 SHALL make err_o 0 in every cycle except a timeout or checksum-mismatch cycle.

Reset
REQ-027 SHALL, while reset_i is 1 at a posedge, go to Idle and set valid_o=0, err_o=0, opcode_o=0, operand_a_o=0, operand_b_o=0, the byte index to 0, the idle counter to 0 and the checksum accumulator to 0.
REQ-028 SHALL drive ready_o=1 from the first cycle after reset is released.
REQ-029 SHALL discard any partial packet or pending request when reset is asserted mid-operation, with no err_o pulse.

Configuration
REQ-030 SHALL, when PARSER_CHECKSUM_EN is defined, accumulate the XOR of the opcode byte and all 8 operand bytes, expect a 10th byte equal to that XOR, issue on a match, and on a mismatch go to Idle, pulse err_o and not issue.
REQ-031 SHALL, when PARSER_CHECKSUM_EN is undefined, use 9-byte packets, omit the Check state and accumulator, and pulse err_o only on timeout.

Verification
REQ-032 SHALL cover: bytes 01 04 03 02 01 08 07 06 05 (no macro) -> next cycle valid_o=1, opcode_o=1, operand_a_o=32'h01020304, operand_b_o=32'h05060708.
REQ-033 SHALL cover: opcode byte 8'h7F plus 8 zero bytes -> opcode_o=0 (Nop), valid_o=1.
REQ-034 SHALL cover: ready_i=0 for 5 cycles after valid_o rises -> outputs stable and ready_o=0 throughout; transfer on cycle 6, then Idle.
REQ-035 SHALL cover: TimeoutCycles=8, 3 bytes sent then 8 idle cycles -> err_o pulses once, no valid_o, a next full packet is parsed correctly.
REQ-036 SHALL cover: with macro, packet 02 + 8 bytes of 8'h11 + check 8'h02 -> issue with opcode_o=2; same packet with check 8'h00 -> err_o pulse, no valid_o.
REQ-037 SHALL cover: reset_i asserted after the 5th byte -> Idle, ready_o=1, the following full packet is parsed correctly with no err_o.
